// File: rtl/data_memory_responder.sv
// Responder for the core data-memory port: wait-stated word SRAM with
// sub-word lanes, load extension, LL/SC reservation and access errors.
module data_memory_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        MemHalf,
   input  logic        MemByte,
   input  logic        MemSignExtend,
   input  logic        LLSC,
   input  logic [31:0] ALUOut,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        MemError
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT =
      (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic        half;
      logic        byt;
      logic        sext;
      logic        llsc;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   req_t        req_q, req_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;
   logic        resv_v_q, resv_v_d;
   logic [29:0] resv_tag_q, resv_tag_d;

   logic [31:0] mem_q [DEPTH_WORDS];
   logic        mem_we;
   logic [31:0] mem_wdata;

   logic [AW-1:0] idx;
   logic [31:0]   rword;
   logic          is_byte, is_half, is_word;
   logic          in_range, acc_err, is_ll, is_sc, tag_hit;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;
   logic [31:0]   load_val, store_val;

   assign idx   = req_q.addr[AW+1:2];
   assign rword = mem_q[idx];

   always_comb begin
      is_byte  = req_q.byt;
      is_half  = req_q.half & ~req_q.byt;
      is_word  = ~req_q.half & ~req_q.byt;
      in_range = req_q.addr[31:2] < DEPTH_L;
      acc_err  = (req_q.rd & req_q.wr)
               | (is_half & req_q.addr[0])
               | (is_word & (|req_q.addr[1:0]))
               | ~in_range;
      is_ll    = req_q.rd & req_q.llsc & is_word;
      is_sc    = req_q.wr & req_q.llsc & is_word;
      tag_hit  = resv_v_q && (resv_tag_q == req_q.addr[31:2]);
   end

   // Little-endian lane extract for loads and lane merge for stores
   always_comb begin
      case (req_q.addr[1:0])
         2'd0:    lane_b = rword[7:0];
         2'd1:    lane_b = rword[15:8];
         2'd2:    lane_b = rword[23:16];
         default: lane_b = rword[31:24];
      endcase
      lane_h = req_q.addr[1] ? rword[31:16] : rword[15:0];

      if (is_byte)
         load_val = {{24{req_q.sext & lane_b[7]}}, lane_b};
      else if (is_half)
         load_val = {{16{req_q.sext & lane_h[15]}}, lane_h};
      else
         load_val = rword;

      store_val = rword;
      if (is_byte) begin
         case (req_q.addr[1:0])
            2'd0:    store_val[7:0]   = req_q.wdata[7:0];
            2'd1:    store_val[15:8]  = req_q.wdata[7:0];
            2'd2:    store_val[23:16] = req_q.wdata[7:0];
            default: store_val[31:24] = req_q.wdata[7:0];
         endcase
      end else if (is_half) begin
         if (req_q.addr[1])
            store_val[31:16] = req_q.wdata[15:0];
         else
            store_val[15:0] = req_q.wdata[15:0];
      end else begin
         store_val = req_q.wdata;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      rdata_d    = rdata_q;
      ready_d    = 1'b0;
      err_d      = 1'b0;
      resv_v_d   = resv_v_q;
      resv_tag_d = resv_tag_q;
      mem_we     = 1'b0;
      mem_wdata  = store_val;

      case (state_q)
         S_IDLE: begin
            if (MemRead | MemWrite) begin
               req_d = '{rd: MemRead, wr: MemWrite, half: MemHalf,
                         byt: MemByte, sext: MemSignExtend, llsc: LLSC,
                         addr: ALUOut, wdata: WriteData};
               cnt_d   = CNT_INIT;
               state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0)
               state_d = S_DONE;
            else
               cnt_d = cnt_q - 4'd1;
         end
         S_DONE: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            if (acc_err) begin
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end else if (req_q.rd) begin
               rdata_d = load_val;
               if (is_ll) begin
                  resv_v_d   = 1'b1;
                  resv_tag_d = req_q.addr[31:2];
               end
            end else if (is_sc) begin
               rdata_d  = {31'd0, tag_hit};
               mem_we   = tag_hit;
               resv_v_d = 1'b0;
            end else begin
               mem_we = 1'b1;
               if (tag_hit)
                  resv_v_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         req_q      <= '0;
         rdata_q    <= 32'd0;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
         resv_v_q   <= 1'b0;
         resv_tag_q <= 30'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         rdata_q    <= rdata_d;
         ready_q    <= ready_d;
         err_q      <= err_d;
         resv_v_q   <= resv_v_d;
         resv_tag_q <= resv_tag_d;
      end
   end

   // Array contents survive reset
   always_ff @(posedge CLK) begin
      if (mem_we)
         mem_q[idx] <= mem_wdata;
   end

   assign ReadData = rdata_q;
   assign MemReady = ready_q;
   assign MemError = err_q;

endmodule
